// File: rtl/i2s_frame_serializer.sv
// I2S (Philips) serializer: a 2-entry stereo sample FIFO feeding one pair per 2*SLOT_BITS-SCLK frame.
// Build option I2S_UNDERRUN_HOLD_EN: an underrun repeats the last popped pair instead of sending zeros.
module i2s_frame_serializer #(
    parameter int DW        = 16,
    parameter int SLOT_BITS = 32
) (
    input  logic          audio_sclk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_l,
    input  logic [DW-1:0] in_r,
    input  logic          mute,
    output logic          audio_lrck,
    output logic          audio_dac,
    output logic          frame_start,
    output logic [7:0]    underrun_cnt,
    output logic [1:0]    fifo_level
);
    localparam int FRAME_BITS = 2 * SLOT_BITS;
    localparam int CW         = $clog2(FRAME_BITS);
    localparam int PW         = 2 * DW;

    localparam logic [CW-1:0] CNT_LAST   = CW'(FRAME_BITS - 1);
    localparam logic [CW-1:0] L_FIRST    = CW'(1);
    localparam logic [CW-1:0] L_LAST     = CW'(DW);
    localparam logic [CW-1:0] R_FIRST    = CW'(SLOT_BITS + 1);
    localparam logic [CW-1:0] R_LAST     = CW'(SLOT_BITS + DW);
    localparam logic [CW-1:0] SLOT_START = CW'(SLOT_BITS);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          lrck_q, lrck_d;
    logic          dac_q, dac_d;
    logic          fs_q, fs_d;
    logic [7:0]    urun_q, urun_d;
    logic [1:0]    level_q, level_d;
    logic          ready_q, ready_d;
    logic          head_q, head_d;
    logic [PW-1:0] mem_q [2];
    logic [PW-1:0] mem_d [2];
    logic [DW-1:0] sh_l_q, sh_l_d;
    logic [DW-1:0] sh_r_q, sh_r_d;
    logic [PW-1:0] last_q, last_d;

    logic          frame_load;
    logic          push;
    logic          pop;
    logic          underrun;
    logic          tail_idx;
    logic [PW-1:0] head_pair;
    logic [PW-1:0] underrun_pair;

`ifdef I2S_UNDERRUN_HOLD_EN
    assign underrun_pair = last_q;
`else
    assign underrun_pair = '0;
`endif

    // FIFO bookkeeping; in_ready is the registered !full of the next level.
    always_comb begin
        frame_load = (cnt_q == CNT_LAST);
        head_pair  = mem_q[head_q];
        tail_idx   = head_q ^ level_q[0];
        push       = in_valid && ready_q;
        pop        = frame_load && !mute && (level_q != 2'd0);
        underrun   = frame_load && (level_q == 2'd0);

        mem_d = mem_q;
        if (push) begin
            mem_d[tail_idx] = {in_l, in_r};
        end

        head_d = pop ? ~head_q : head_q;

        case ({push, pop})
            2'b10:   level_d = level_q + 2'd1;
            2'b01:   level_d = level_q - 2'd1;
            default: level_d = level_q;
        endcase

        ready_d = (level_d != 2'd2);
        last_d  = pop ? head_pair : last_q;
        urun_d  = (underrun && (urun_q != 8'hFF)) ? urun_q + 8'd1 : urun_q;
    end

    // Frame timing and serial data; outputs are registered against the next count
    // so they line up with bit_cnt after every falling edge.
    always_comb begin
        cnt_d  = frame_load ? '0 : cnt_q + CW'(1);
        lrck_d = (cnt_d >= SLOT_START);
        fs_d   = (cnt_d == '0);
        dac_d  = 1'b0;
        sh_l_d = sh_l_q;
        sh_r_d = sh_r_q;

        if (frame_load) begin
            if (mute) begin
                {sh_l_d, sh_r_d} = '0;
            end else if (level_q != 2'd0) begin
                {sh_l_d, sh_r_d} = head_pair;
            end else begin
                {sh_l_d, sh_r_d} = underrun_pair;
            end
        end else if ((cnt_d >= L_FIRST) && (cnt_d <= L_LAST)) begin
            dac_d  = sh_l_q[DW-1];
            sh_l_d = sh_l_q << 1;
        end else if ((cnt_d >= R_FIRST) && (cnt_d <= R_LAST)) begin
            dac_d  = sh_r_q[DW-1];
            sh_r_d = sh_r_q << 1;
        end
    end

    always_ff @(negedge audio_sclk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            lrck_q   <= 1'b0;
            dac_q    <= 1'b0;
            fs_q     <= 1'b0;
            urun_q   <= '0;
            level_q  <= '0;
            ready_q  <= 1'b1;
            head_q   <= 1'b0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            sh_l_q   <= '0;
            sh_r_q   <= '0;
            last_q   <= '0;
        end else begin
            cnt_q    <= cnt_d;
            lrck_q   <= lrck_d;
            dac_q    <= dac_d;
            fs_q     <= fs_d;
            urun_q   <= urun_d;
            level_q  <= level_d;
            ready_q  <= ready_d;
            head_q   <= head_d;
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            sh_l_q   <= sh_l_d;
            sh_r_q   <= sh_r_d;
            last_q   <= last_d;
        end
    end

    assign in_ready     = ready_q;
    assign audio_lrck   = lrck_q;
    assign audio_dac    = dac_q;
    assign frame_start  = fs_q;
    assign underrun_cnt = urun_q;
    assign fifo_level   = level_q;

endmodule

// File: tb/tb_i2s_frame_serializer.sv
// Bench for i2s_frame_serializer: directed pairs, expected frames queued by the driver and
// checked bit-for-bit by a frame monitor that tracks its own SCLK position.
module tb_i2s_frame_serializer;
  localparam int DW = 16;

`ifdef I2S_UNDERRUN_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_l = '0;
  logic [DW-1:0] in_r = '0;
  logic          mute = 1'b0;
  logic          audio_lrck;
  logic          audio_dac;
  logic          frame_start;
  logic [7:0]    underrun_cnt;
  logic [1:0]    fifo_level;

  int   tests = 0;
  int   fails = 0;
  int   pos = 0;
  int   frame_no = 0;
  logic mon_en = 1'b0;

  // {frame number, left, right}
  logic [47:0] exp_q[$];
  logic [47:0] e_ent;
  logic [63:0] exp_dac;
  logic [63:0] dac_v, lrck_v, fs_v;

  logic [15:0] s_l [6];
  logic [15:0] s_r [6];

  i2s_frame_serializer #(.DW(DW), .SLOT_BITS(32)) dut (
    .audio_sclk  (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_l        (in_l),
    .in_r        (in_r),
    .mute        (mute),
    .audio_lrck  (audio_lrck),
    .audio_dac   (audio_dac),
    .frame_start (frame_start),
    .underrun_cnt(underrun_cnt),
    .fifo_level  (fifo_level)
  );

  // clock / position tracking
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!mon_en) begin
      pos      <= 0;
      frame_no <= 0;
    end else begin
      if (pos == 63) frame_no <= frame_no + 1;
      pos <= (pos == 63) ? 0 : pos + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] urun_pair(input logic [31:0] last);
    return HOLD ? last : 32'h0;
  endfunction

  task automatic expect_frame(input int f, input logic [31:0] pair);
    exp_q.push_back({16'(f), pair});
  endtask

  // monitor: collect one frame of outputs, compare at its last bit
  always @(posedge clk) begin
    if (mon_en) begin
      dac_v[pos]  = audio_dac;
      lrck_v[pos] = audio_lrck;
      fs_v[pos]   = frame_start;
      if (pos == 63) begin
        chk($sformatf("lrck_f%0d", frame_no), lrck_v, {32'hFFFF_FFFF, 32'h0});
        chk($sformatf("fs_f%0d", frame_no), fs_v, (frame_no == 0) ? 64'h0 : 64'h1);
        while (exp_q.size() > 0 && int'(exp_q[0][47:32]) < frame_no) begin
          e_ent = exp_q.pop_front();
          chk("sb_stale_frame", 64'(e_ent[47:32]), 64'(frame_no));
        end
        if (exp_q.size() > 0 && int'(exp_q[0][47:32]) == frame_no) begin
          e_ent   = exp_q.pop_front();
          exp_dac = '0;
          for (int i = 0; i < 16; i++) begin
            exp_dac[1 + i]  = e_ent[31 - i];
            exp_dac[33 + i] = e_ent[15 - i];
          end
          chk($sformatf("dac_f%0d", frame_no), dac_v, exp_dac);
        end
      end
    end
  end

  // driver tasks
  task automatic wait_at(input int f, input int p);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!(frame_no == f && pos == p) && n < 30000);
    if (!(frame_no == f && pos == p)) begin
      tests++;
      fails++;
      $display("FAIL wait_f%0d_p%0d: reached frame %0d pos %0d", f, p, frame_no, pos);
    end
  endtask

  task automatic push_pair(input string name, input logic [15:0] l, input logic [15:0] r);
    chk({name, "_ready"}, 64'(in_ready), 64'h1);
    in_valid = 1'b1;
    in_l     = l;
    in_r     = r;
    @(negedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic apply_reset(input string name);
    mon_en = 1'b0;
    reset  = 1'b1;
    #1;
    chk({name, "_dac"}, 64'(audio_dac), 64'h0);
    chk({name, "_lrck"}, 64'(audio_lrck), 64'h0);
    chk({name, "_fs"}, 64'(frame_start), 64'h0);
    chk({name, "_level"}, 64'(fifo_level), 64'h0);
    chk({name, "_ready"}, 64'(in_ready), 64'h1);
    chk({name, "_urun"}, 64'(underrun_cnt), 64'h0);
    repeat (2) @(negedge clk);
    #2;
    reset  = 1'b0;
    mon_en = 1'b1;
  endtask

  initial begin
    int n;
    s_l[0] = 16'h8001; s_r[0] = 16'h7FFE;
    s_l[1] = 16'h0001; s_r[1] = 16'hFFFF;
    s_l[2] = 16'h5555; s_r[2] = 16'hAAAA;
    s_l[3] = 16'hFFFF; s_r[3] = 16'h0000;
    s_l[4] = 16'h0F0F; s_r[4] = 16'hF0F0;
    s_l[5] = 16'h1234; s_r[5] = 16'h8000;

    #2;
    apply_reset("rst0");

    // first pair: frame 0 is silent, pair appears in frame 1, then one underrun
    expect_frame(0, 32'h0);
    wait_at(0, 5);
    push_pair("t1", 16'hA5C3, 16'h0F0F);
    chk("t1_level", 64'(fifo_level), 64'h1);
    expect_frame(1, 32'hA5C3_0F0F);
    expect_frame(2, urun_pair(32'hA5C3_0F0F));
    wait_at(1, 10);
    chk("t1_urun_f1", 64'(underrun_cnt), 64'h0);
    chk("t1_level_f1", 64'(fifo_level), 64'h0);
    wait_at(2, 10);
    chk("t1_urun_f2", 64'(underrun_cnt), 64'h1);

    // continuous in_valid: two fills, then one accept per frame
    wait_at(2, 20);
    for (int k = 0; k < 6; k++) expect_frame(3 + k, {s_l[k], s_r[k]});
    in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_l = s_l[k];
      in_r = s_r[k];
      n = 0;
      while (!in_ready && n < 200) begin
        @(posedge clk);
        n++;
      end
      chk($sformatf("s%0d_ready", k), 64'(in_ready), 64'h1);
      if (k >= 2) begin
        chk($sformatf("s%0d_level_before", k), 64'(fifo_level), 64'h1);
        chk($sformatf("s%0d_pos_before", k), 64'(pos), 64'h0);
      end
      @(negedge clk);
      @(posedge clk);
      if (k >= 1) begin
        chk($sformatf("s%0d_level_after", k), 64'(fifo_level), 64'h2);
        chk($sformatf("s%0d_ready_after", k), 64'(in_ready), 64'h0);
      end
    end
    in_valid = 1'b0;

    // starvation after 0x1234/0x8000
    for (int f = 9; f <= 12; f++) expect_frame(f, urun_pair(32'h1234_8000));
    wait_at(9, 10);
    chk("u_urun_f9", 64'(underrun_cnt), 64'h2);
    wait_at(10, 10);
    chk("u_urun_f10", 64'(underrun_cnt), 64'h3);
    wait_at(11, 10);
    chk("u_urun_f11", 64'(underrun_cnt), 64'h4);

    // mute at load with one pair queued
    wait_at(12, 5);
    push_pair("m", 16'h7F01, 16'h00FE);
    expect_frame(13, 32'h0);
    expect_frame(14, 32'h7F01_00FE);
    expect_frame(15, urun_pair(32'h7F01_00FE));
    wait_at(12, 10);
    chk("m_urun_f12", 64'(underrun_cnt), 64'h5);
    wait_at(12, 60);
    mute = 1'b1;
    wait_at(13, 2);
    mute = 1'b0;
    wait_at(13, 10);
    chk("m_level_f13", 64'(fifo_level), 64'h1);
    chk("m_urun_f13", 64'(underrun_cnt), 64'h5);
    wait_at(14, 10);
    chk("m_level_f14", 64'(fifo_level), 64'h0);
    chk("m_urun_f14", 64'(underrun_cnt), 64'h5);
    wait_at(15, 10);
    chk("m_urun_f15", 64'(underrun_cnt), 64'h6);

    // saturation
    wait_at(263, 10);
    chk("sat_urun_f263", 64'(underrun_cnt), 64'd254);
    wait_at(264, 10);
    chk("sat_urun_f264", 64'(underrun_cnt), 64'd255);
    wait_at(300, 10);
    chk("sat_urun_f300", 64'(underrun_cnt), 64'd255);

    // reset in the middle of a right slot carrying ones
    wait_at(301, 3);
    push_pair("r1", 16'hFFFF, 16'hFFFF);
    expect_frame(302, 32'hFFFF_FFFF);
    wait_at(302, 3);
    push_pair("r2", 16'h1111, 16'h2222);
    wait_at(302, 40);
    chk("pre_rst_dac", 64'(audio_dac), 64'h1);
    chk("pre_rst_lrck", 64'(audio_lrck), 64'h1);
    chk("pre_rst_level", 64'(fifo_level), 64'h1);
    exp_q.delete();
    apply_reset("rst1");
    expect_frame(0, 32'h0);
    expect_frame(1, 32'h0);
    wait_at(1, 10);
    chk("post_rst_urun", 64'(underrun_cnt), 64'h1);
    chk("post_rst_level", 64'(fifo_level), 64'h0);
    wait_at(2, 1);
    chk("sb_empty", 64'(exp_q.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
